seq_divider_16: RTL and testbench
=================================

Name: seq_divider_16

Overview:
Iterative radix-2 restoring unsigned divider, the inverse operation to the team's array multiplier datapath. It accepts a dividend/divisor pair on a start pulse and retires one quotient bit per clock. It asserts a one-cycle done pulse when the results are valid. It sits beside the multiplier as the divide path of the arithmetic unit and shares the same single clock and reset.

Parameters:
WIDTH, 16, operand, quotient and remainder width in bits (must be >= 2)

Ports:
clk  input  1  system clock; all state updates on its rising edge
rst  input  1  reset; asynchronous, active-high
start  input  1  request a division; sampled only in IDLE
dividend  input  WIDTH  unsigned dividend; captured on accepted start
divisor  input  WIDTH  unsigned divisor; captured on accepted start
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse; quotient, remainder and div_by_zero valid
quotient  output  WIDTH  unsigned quotient
remainder  output  WIDTH  unsigned remainder
div_by_zero  output  1  the last completed operation had divisor == 0

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state IDLE, busy 0, done 0, quotient 0, remainder 0, div_by_zero 0. Internal registers (operands, partial remainder, bit counter) are also cleared.
- Reset mid-operation: the operation is aborted immediately, no done pulse is produced, and all outputs return to their reset values.
- FSM states:
  - IDLE -> RUN when start=1 and the captured divisor != 0. Captures the operands, clears the partial remainder and sets count=WIDTH.
  - IDLE -> DONE when start=1 and divisor == 0. No iterations are performed.
  - RUN -> RUN while count > 1. RUN -> DONE on the iteration where count == 1.
  - DONE -> IDLE unconditionally after one cycle.
- Start handling: start is ignored whenever state != IDLE. The operand inputs are don't-care outside the accepting cycle.
- RUN iteration (one per cycle):
  - Shift {partial remainder, dividend shift register} left by 1.
  - Compute trial = shifted remainder (WIDTH+1 bits) minus zero-extended divisor.
  - If trial bit WIDTH is 0 (non-negative): the remainder becomes trial[WIDTH-1:0] and quotient LSB = 1.
  - Otherwise: the remainder keeps the shifted value and quotient LSB = 0.
  - Decrement count.
- Latency: start accepted at edge 0 -> done high during cycle WIDTH+1 (cycle 17 for WIDTH=16).
- Divide-by-zero: done high during cycle 1, with quotient all-ones, remainder = dividend and div_by_zero = 1.
- Output registers:
  - quotient, remainder and div_by_zero load in the cycle done is asserted.
  - They hold their values until the next operation reaches DONE, and do not change during RUN.
  - div_by_zero is cleared by a subsequent non-zero-divisor completion.
- Back-to-back: earliest new start is the cycle after done (state IDLE). No throughput beyond 1 op per WIDTH+2 cycles.
- busy: high from the cycle after the accepted start through the done cycle inclusive.
- Arithmetic: the subtract path is WIDTH+1 bits wide, so a remainder MSB shifted out is never lost (matters for divisor > 2^(WIDTH-1)). Invariant on completion: dividend == quotient*divisor + remainder, and remainder < divisor.

Decomposition:
- Shared arithmetic package: WIDTH default, FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the counter width constant $clog2(WIDTH+1).
- One natural sub-module: div_step.
  - Purely combinational restoring step.
  - Inputs: partial remainder, incoming dividend bit, divisor.
  - Outputs: next remainder and quotient bit, with the WIDTH+1 subtract inside.
  - Instantiated once and reused each cycle. The FSM, counter and output registers stay in seq_divider_16.

Test Plan:
- 100 / 7, start at cycle 0 -> done pulse exactly in cycle 17, quotient=14, remainder=2, div_by_zero=0, busy low in cycle 18.
- 0xFFFF / 0x0001 -> quotient=0xFFFF, remainder=0; then 0x8000 / 0x8001 -> quotient=0, remainder=0x8000 (exercises the WIDTH+1 subtract).
- 5 / 0 -> done in cycle 1, quotient=0xFFFF, remainder=5, div_by_zero=1; next 9 / 3 -> quotient=3, remainder=0, div_by_zero=0.
- 3 / 10 -> quotient=0, remainder=3.
- Start with 50/5 at cycle 0, then start pulsed with 7/2 at cycle 5 -> second request ignored, single done pulse with quotient=10, remainder=0; outputs stable through RUN.
- Start 1000/3, assert rst at cycle 8 for one cycle -> outputs/busy zero immediately, no done pulse; then 0xFFFE/0x00FF -> quotient=0x0100, remainder=0x00FE; plus a randomized 1000-op run checking the invariant.

Source files
------------

// File: rtl/seq_divider_16_pkg.sv
// Shared definitions for the sequential restoring divider: default width,
// FSM state encoding and the iteration-counter width helper.
package seq_divider_16_pkg;

    localparam int WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    localparam int CNT_W_DEF = cnt_width(WIDTH_DEF);

endpackage

// File: rtl/seq_divider_16_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the
// divisor on a WIDTH+1 bit path, keep the difference when it does not go negative.
module div_step
    import seq_divider_16_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    always_comb begin
        shifted  = {rem, bit_in};
        trial    = shifted - {1'b0, divisor};
        q_bit    = ~trial[WIDTH];
        // A non-negative trial is below the divisor, so it fits in WIDTH bits.
        rem_next = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_divider_16.sv
// Iterative radix-2 restoring unsigned divider: one quotient bit per clock,
// one-cycle done pulse with registered quotient, remainder and div_by_zero.
module seq_divider_16
    import seq_divider_16_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] dvd_sr;
    logic [WIDTH-1:0] dvs_r;
    logic [WIDTH-1:0] rem_p;
    logic [WIDTH-1:0] rem_next;
    logic             q_bit;
    logic [CNT_W-1:0] cnt;

    // Dividend bits leave at the top while quotient bits enter at the bottom,
    // so after WIDTH steps dvd_sr holds the quotient.
    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_p),
        .bit_in   (dvd_sr[WIDTH-1]),
        .divisor  (dvs_r),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            dvd_sr      <= '0;
            dvs_r       <= '0;
            rem_p       <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        dvd_sr <= dividend;
                        dvs_r  <= divisor;
                        rem_p  <= '0;
                        busy   <= 1'b1;
                        if (divisor == '0) begin
                            state       <= DONE;
                            cnt         <= '0;
                            done        <= 1'b1;
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            state <= RUN;
                            cnt   <= CNT_W'(WIDTH);
                        end
                    end
                end
                RUN: begin
                    dvd_sr <= {dvd_sr[WIDTH-2:0], q_bit};
                    rem_p  <= rem_next;
                    cnt    <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state       <= DONE;
                        done        <= 1'b1;
                        quotient    <= {dvd_sr[WIDTH-2:0], q_bit};
                        remainder   <= rem_next;
                        div_by_zero <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider_16.sv
// Scoreboard bench for seq_divider_16: the driver queues expected results,
// a monitor pops and compares them on every done pulse.
module tb_seq_divider_16;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic [15:0] r;
        logic        z;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;
    int   done_cnt = 0;

    logic [15:0] last_q = '0;
    logic [15:0] last_r = '0;
    logic        last_z = 1'b0;

    seq_divider_16 dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            exp_t e;
            done_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("quotient", quotient, e.q);
                chk("remainder", remainder, e.r);
                chk("div_by_zero", div_by_zero, e.z);
                if (e.b != 0) begin
                    chk("invariant", 32'(quotient) * 32'(e.b) + 32'(remainder), 32'(e.a));
                    chk("rem_lt_div", 32'(remainder < e.b), 32'd1);
                end
            end
        end
    end

    // inj: cycle at which an (ignored) start is pulsed; rst_at: cycle to reset.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] eq, input logic [15:0] er, input logic ez,
                          input int elat, input int inj, input int rst_at);
        int  k;
        bit  seen;
        int  dc0;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        if (rst_at < 0) sb.push_back('{a, b, eq, er, ez});
        @(posedge clk);
        k    = 1;
        seen = 0;
        while (!seen && k <= 40) begin
            @(negedge clk);
            start    = 1'b0;
            dividend = 16'($urandom);
            divisor  = 16'($urandom);
            if (k == inj) begin
                start    = 1'b1;
                dividend = 16'd7;
                divisor  = 16'd2;
            end
            if (k == rst_at) begin
                dc0 = done_cnt;
                rst = 1'b1;
                #1;
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_quotient", quotient, 0);
                chk("rst_remainder", remainder, 0);
                chk("rst_dbz", div_by_zero, 0);
                @(negedge clk);
                rst = 1'b0;
                repeat (30) @(negedge clk);
                chk("no_done_after_rst", done_cnt, dc0);
                last_q = '0;
                last_r = '0;
                last_z = 1'b0;
                return;
            end
            if (done) begin
                seen = 1;
            end else begin
                chk("busy_run", busy, 1);
                chk("hold_quotient", quotient, last_q);
                chk("hold_remainder", remainder, last_r);
                chk("hold_dbz", div_by_zero, last_z);
                k++;
            end
        end
        if (!seen) begin
            chk("done_timeout", 32'd0, 32'd1);
        end else begin
            chk("latency", k, elat);
            @(negedge clk);
            chk("busy_after", busy, 0);
            chk("done_width", done, 0);
        end
        last_q = eq;
        last_r = er;
        last_z = ez;
    endtask

    initial begin
        logic [15:0] a;
        logic [15:0] b;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #12;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_quotient", quotient, 0);
        chk("reset_remainder", remainder, 0);
        chk("reset_dbz", div_by_zero, 0);
        @(negedge clk);
        rst = 1'b0;

        run_op(16'd100,   16'd7,      16'd14,     16'd2,      1'b0, 17, -1, -1);
        run_op(16'hFFFF,  16'h0001,   16'hFFFF,   16'h0000,   1'b0, 17, -1, -1);
        run_op(16'h8000,  16'h8001,   16'h0000,   16'h8000,   1'b0, 17, -1, -1);
        run_op(16'd5,     16'd0,      16'hFFFF,   16'd5,      1'b1, 1,  -1, -1);
        run_op(16'd9,     16'd3,      16'd3,      16'd0,      1'b0, 17, -1, -1);
        run_op(16'd3,     16'd10,     16'd0,      16'd3,      1'b0, 17, -1, -1);
        run_op(16'd50,    16'd5,      16'd10,     16'd0,      1'b0, 17, 5,  -1);
        repeat (25) @(negedge clk);
        run_op(16'd1000,  16'd3,      16'd333,    16'd1,      1'b0, 17, -1, 8);
        run_op(16'hFFFE,  16'h00FF,   16'h0100,   16'h00FE,   1'b0, 17, -1, -1);

        for (int i = 0; i < 1000; i++) begin
            a = 16'($urandom);
            case ($urandom_range(0, 3))
                0: b = 16'($urandom_range(0, 15));
                1: b = 16'($urandom_range(16'h8000, 16'hFFFF));
                default: b = 16'($urandom);
            endcase
            if (b == 0) run_op(a, b, 16'hFFFF, a, 1'b1, 1, -1, -1);
            else        run_op(a, b, a / b, a % b, 1'b0, 17, -1, -1);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
